// File: rtl/irq_ack_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ack_dispatch
//  Purpose  : CPU-side responder for the interrupt controller. Accepts an
//             encoded interrupt index, pulses a one-hot acknowledge on the
//             originating line, waits out a fixed service window, then
//             pulses a one-hot end-of-interrupt on the same line. Masked
//             requests are consumed and counted as spurious.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_ack_dispatch #(
    parameter int N_IRQ          = 4,
    parameter int ID_W           = $clog2(N_IRQ),
    parameter int SERVICE_CYCLES = 3,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             irq_valid,
    input  logic [ID_W-1:0]  irq_id,
    output logic             irq_ready,
    input  logic [N_IRQ-1:0] mask,
    output logic [N_IRQ-1:0] ack,
    output logic             busy,
    output logic [ID_W-1:0]  active_id,
    output logic [N_IRQ-1:0] eoi,
    output logic [CNT_W-1:0] spurious_cnt
);

    // Service counter only needs to hold SERVICE_CYCLES-1; keep at least one bit.
    localparam int SVC_W = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;

    localparam logic [SVC_W-1:0] c_svc_load = SVC_W'(SERVICE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [N_IRQ-1:0] c_line0    = {{(N_IRQ-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_ack     = 2'd1;
    localparam logic [1:0] c_st_service = 2'd2;
    localparam logic [1:0] c_st_eoi     = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [ID_W-1:0]  r_active_id;
    logic [SVC_W-1:0] r_svc_cnt;
    logic [CNT_W-1:0] r_spur_cnt;

    logic             w_accept;
    logic             w_masked;
    logic [N_IRQ-1:0] w_active_onehot;

    // A handshake can only happen in IDLE; the mask is looked at only then.
    assign w_accept        = irq_valid && (r_state == c_st_idle);
    assign w_masked        = mask[irq_id];
    assign w_active_onehot = c_line0 << r_active_id;

    // State register; reset aborts any interrupt in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept unmasked request, ack, serve, end-of-interrupt.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept && !w_masked) begin
                    w_state_nxt = c_st_ack;
                end
            end
            c_st_ack: begin
                w_state_nxt = c_st_service;
            end
            c_st_service: begin
                if (r_svc_cnt == '0) begin
                    w_state_nxt = c_st_eoi;
                end
            end
            c_st_eoi: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Outputs decode purely from registered state, so irq_* never reaches ack/eoi combinationally.
    always_comb begin
        irq_ready = 1'b0;
        busy      = 1'b1;
        ack       = '0;
        eoi       = '0;
        case (r_state)
            c_st_idle: begin
                irq_ready = 1'b1;
                busy      = 1'b0;
            end
            c_st_ack: begin
                ack = w_active_onehot;
            end
            c_st_eoi: begin
                eoi = w_active_onehot;
            end
            default: begin
            end
        endcase
    end

    // Datapath: latch the accepted index, run the service countdown, count spurious requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active_id <= '0;
            r_svc_cnt   <= '0;
            r_spur_cnt  <= '0;
        end else begin
            if (w_accept && !w_masked) begin
                r_active_id <= irq_id;
            end
            if (w_accept && w_masked && (r_spur_cnt != c_cnt_max)) begin
                r_spur_cnt <= r_spur_cnt + 1'b1;
            end
            if (r_state == c_st_ack) begin
                r_svc_cnt <= c_svc_load;
            end else if ((r_state == c_st_service) && (r_svc_cnt != '0)) begin
                r_svc_cnt <= r_svc_cnt - 1'b1;
            end
        end
    end

    assign active_id    = r_active_id;
    assign spurious_cnt = r_spur_cnt;

endmodule
`default_nettype wire

// File: doc/irq_ack_dispatch.md
Name: irq_ack_dispatch

Overview:
- CPU-side responder for the interrupt controller's priority encoder.
- Accepts an encoded interrupt index (irq_id) with a valid/ready handshake and decodes it back into a one-hot acknowledge pulse on the originating line.
- Models a fixed-length service window, then issues a one-hot end-of-interrupt (EOI) pulse.
- Sits between the interrupt controller and the interrupt sources, closing the request/ack loop.

Parameters:
- N_IRQ, 4, number of interrupt lines; itr0 is the highest priority.
- ID_W, $clog2(N_IRQ) = 2, width of the encoded index.
- SERVICE_CYCLES, 3, cycles spent in service per interrupt; must be >= 1.
- CNT_W, 8, width of the saturating spurious-interrupt counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- irq_valid  input  1  the controller has an encoded interrupt pending.
- irq_id  input  ID_W  encoded interrupt index (0 = itr0).
- irq_ready  output  1  the dispatcher can accept an index this cycle.
- mask  input  N_IRQ  per-line mask; 1 = masked.
- ack  output  N_IRQ  one-hot acknowledge; a 1-cycle pulse.
- busy  output  1  an interrupt is being acknowledged or serviced.
- active_id  output  ID_W  index currently being handled.
- eoi  output  N_IRQ  one-hot end-of-interrupt; a 1-cycle pulse.
- spurious_cnt  output  CNT_W  count of masked requests that were accepted.

Behaviour:
- Reset: synchronous. rst_n low at a rising edge forces the following state:
  - state = IDLE
  - ack = 0, eoi = 0, busy = 0
  - active_id = 0, spurious_cnt = 0
  - service counter = 0
  - irq_ready = 1 from the first cycle after reset releases.
- FSM states: IDLE, ACK, SERVICE, EOI. All outputs decode from registered state or registers; there is no combinational path from irq_* to ack/eoi.
- IDLE:
  - irq_ready = 1, busy = 0.
  - Handshake occurs when irq_valid && irq_ready at the edge.
  - If mask[irq_id] = 1: the request is consumed, spurious_cnt increments (saturating at 2^CNT_W-1, no wrap), and the FSM stays in IDLE. No ack is issued.
  - If mask[irq_id] = 0: irq_id is latched into active_id and the FSM goes to ACK.
  - irq_valid = 0: no change.
- ACK:
  - ack[active_id] = 1 for exactly one cycle; busy = 1; irq_ready = 0.
  - The service counter loads SERVICE_CYCLES-1.
  - Next state: SERVICE.
- SERVICE:
  - busy = 1, irq_ready = 0.
  - The counter decrements each cycle. In the cycle the counter is 0, the next state is EOI.
  - The state lasts exactly SERVICE_CYCLES cycles.
- EOI:
  - eoi[active_id] = 1 for one cycle; busy = 1; irq_ready = 0.
  - Next state: IDLE.
  - active_id holds its value until the next accepted unmasked request.
- Latency: ack is high in the cycle immediately after the accept edge. eoi is high SERVICE_CYCLES+1 cycles after ack. irq_ready returns the cycle after eoi. A new request is therefore accepted at most every SERVICE_CYCLES+3 cycles.
- Back-to-back: irq_valid held high with a new id is accepted on the first IDLE edge after EOI. No idle bubble beyond the IDLE cycle itself.
- Requests while not ready: ignored. The controller is required to hold irq_valid/irq_id until irq_ready.
- Mask changes after accept do not affect the in-flight interrupt. The mask is sampled only at the accept edge.
- ack and eoi are always one-hot or zero, never multi-bit.
- Reset in ACK/SERVICE/EOI aborts the interrupt: no eoi is issued for the aborted interrupt, and spurious_cnt clears.

Test Plan:
- Reset: hold rst_n=0 for 2 edges, release → irq_ready=1, busy=0, ack=0, eoi=0, spurious_cnt=0, active_id=0.
- Single unmasked request: irq_id=2, mask=0, valid for 1 cycle at edge T → ack=4'b0100 during T+1 only; busy=1 from T+1 to T+5; eoi=4'b0100 at T+5; irq_ready=1 at T+6.
- Back-to-back: valid held with id=0, then id=3 → ack=0001, then eoi=0001, then IDLE for one cycle, then ack=1000. Cycle gap from ack to ack is 6.
- Masked request: mask=4'b0010, id=1, valid for 1 cycle → no ack/eoi, spurious_cnt=1, irq_ready stays 1.
  - Repeat 300 masked requests → spurious_cnt saturates at 255.
- Mask after accept: accept id=3 with mask=0, set mask=4'b1000 during SERVICE → eoi=1000 is still issued on schedule.
- Reset mid-service: accept id=1, drop rst_n during the 2nd SERVICE cycle → next cycle busy=0, no eoi pulse, irq_ready=1 after release.
